bus_packet_buffer: RTL and testbench

- Store-and-forward beat FIFO on the 32-bit bus side of the user top.
- Sits directly downstream of the to-bus adapter's out$enq stream and drives the external read$enq bus.
- Releases a packet only after its last beat has been accepted, so the external bus never sees a stalled partial packet.
- Falls back to cut-through when a single packet exceeds buffer capacity, which avoids deadlock.

---
 rtl/bus_packet_buffer_if.sv | 9 +
 rtl/bus_packet_buffer.sv | 49 ++++
 tb/tb_bus_packet_buffer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_packet_buffer_if.sv
// bus_packet_buffer_if: one beat stream (valid/ready handshake with 32-bit data and last flag)
interface bus_packet_buffer_if;
  logic        ENA;
  logic [31:0] v;
  logic        last;
  logic        RDY;
  modport master (output ENA, v, last, input RDY);
  modport slave  (input ENA, v, last, output RDY);
endinterface

// File: rtl/bus_packet_buffer.sv
// bus_packet_buffer: store-and-forward beat FIFO that falls back to cut-through for oversize packets
module bus_packet_buffer #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                CLK,
  input  logic                nRST,
  bus_packet_buffer_if.slave  in_enq,
  bus_packet_buffer_if.master out_enq,
  output logic [AW:0]         pkt_count,
  output logic [31:0]         pkts_sent,
  output logic                cut_through
);
  typedef enum logic {NORMAL, CUT} state_t;
  state_t state, state_nxt;
  logic [32:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic empty, full, in_x, out_x, in_l, out_l;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr[AW-1:0] == rd_ptr[AW-1:0] && wr_ptr[AW] != rd_ptr[AW];
  assign in_enq.RDY = !full;
  assign {out_enq.last, out_enq.v} = mem[rd_ptr[AW-1:0]];
  assign cut_through = state == CUT;
  assign out_enq.ENA = !empty && (pkt_count != '0 || cut_through);
  assign in_x = in_enq.ENA && !full;
  assign out_x = out_enq.ENA && out_enq.RDY;
  assign in_l = in_x && in_enq.last;
  assign out_l = out_x && out_enq.last;
  always_comb
    state_nxt = (state == NORMAL && full && pkt_count == '0) ? CUT :
                (state == CUT && out_l)                        ? NORMAL : state;
  always_ff @(posedge CLK)
    if (in_x)
      mem[wr_ptr[AW-1:0]] <= {in_enq.last, in_enq.v};
  always_ff @(posedge CLK)
    if (!nRST) begin
      state     <= NORMAL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pkt_count <= '0;
      pkts_sent <= '0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr + (AW+1)'(in_x);
      rd_ptr    <= rd_ptr + (AW+1)'(out_x);
      pkt_count <= pkt_count + (AW+1)'(in_l) - (AW+1)'(out_l);
      pkts_sent <= pkts_sent + 32'(out_l);
    end
endmodule

// File: tb/tb_bus_packet_buffer.sv
// tb_bus_packet_buffer: directed and random stimulus against a queue-based packet buffer model
module tb_bus_packet_buffer;
  localparam int DEPTH = 16;
  logic CLK = 0;
  logic nRST = 0;
  logic [4:0] pkt_count;
  logic [31:0] pkts_sent;
  logic cut_through;
  bus_packet_buffer_if in_if ();
  bus_packet_buffer_if out_if ();
  bus_packet_buffer #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .in_enq(in_if), .out_enq(out_if),
    .pkt_count(pkt_count), .pkts_sent(pkts_sent), .cut_through(cut_through)
  );
  always #5 CLK = ~CLK;
  int total = 0;
  int bad = 0;
  logic [32:0] q[$];
  logic [31:0] exp_sent = 0;
  bit exp_cut = 0;
  bit armed = 0;
  bit saw_cut = 0;
  bit done = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  always @(negedge CLK) begin
    int pk;
    bit ex_ena, ex_rdy, ix, ox, nxt_cut;
    logic [32:0] h;
    if (cut_through === 1'b1) saw_cut = 1;
    if (!nRST) begin
      q.delete();
      exp_sent = 0;
      exp_cut = 0;
      armed = 1;
    end else if (armed) begin
      pk = 0;
      foreach (q[i]) pk += int'(q[i][32]);
      ex_rdy = q.size() < DEPTH;
      ex_ena = q.size() != 0 && (pk != 0 || exp_cut);
      chk("in_rdy", 64'(in_if.RDY), 64'(ex_rdy));
      chk("out_ena", 64'(out_if.ENA), 64'(ex_ena));
      chk("pkt_count", 64'(pkt_count), 64'(pk));
      chk("pkts_sent", 64'(pkts_sent), 64'(exp_sent));
      chk("cut_through", 64'(cut_through), 64'(exp_cut));
      ix = in_if.ENA && ex_rdy;
      ox = ex_ena && out_if.RDY;
      nxt_cut = exp_cut;
      if (!exp_cut && q.size() == DEPTH && pk == 0) nxt_cut = 1;
      if (ox) begin
        h = q.pop_front();
        chk("out_beat", 64'({out_if.last, out_if.v}), 64'(h));
        if (h[32]) begin
          exp_sent++;
          nxt_cut = 0;
        end
      end
      if (ix) q.push_back({in_if.last, in_if.v});
      exp_cut = nxt_cut;
    end
  end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic beat(input logic [31:0] v, input logic l);
    int n;
    n = 0;
    in_if.ENA = 1;
    in_if.v = v;
    in_if.last = l;
    @(negedge CLK);
    while (!in_if.RDY && n < 400) begin
      n++;
      @(negedge CLK);
    end
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL beat_timeout got=stalled want=accepted data=%0h", v);
    end
    tick();
    in_if.ENA = 0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got=%0d want=0 beats left", q.size());
    end
    tick();
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int sent, len;
    in_if.ENA = 0;
    in_if.v = 0;
    in_if.last = 0;
    out_if.RDY = 1;
    nRST = 0;
    tick();
    tick();
    nRST = 1;
    @(negedge CLK);
    chk("rst_out_ena", 64'(out_if.ENA), 0);
    chk("rst_in_rdy", 64'(in_if.RDY), 1);
    tick();
    beat(32'h11, 0);
    beat(32'h22, 0);
    beat(32'h33, 1);
    drain();
    @(negedge CLK);
    chk("t1_pkts_sent", 64'(pkts_sent), 1);
    chk("t1_pkt_count", 64'(pkt_count), 0);
    tick();
    out_if.RDY = 0;
    for (int p = 0; p < 4; p++)
      for (int b = 0; b < 4; b++) beat(32'h100 + 32'(p * 4 + b), b == 3);
    @(negedge CLK);
    chk("t2_in_rdy", 64'(in_if.RDY), 0);
    chk("t2_pkt_count", 64'(pkt_count), 4);
    tick();
    out_if.RDY = 1;
    drain();
    @(negedge CLK);
    chk("t2_pkts_sent", 64'(pkts_sent), 5);
    tick();
    saw_cut = 0;
    for (int b = 0; b < 20; b++) beat(32'h200 + 32'(b), b == 19);
    drain();
    @(negedge CLK);
    chk("t3_saw_cut", 64'(saw_cut), 1);
    chk("t3_cut_cleared", 64'(cut_through), 0);
    chk("t3_pkts_sent", 64'(pkts_sent), 6);
    tick();
    out_if.RDY = 0;
    beat(32'h44, 1);
    beat(32'h55, 0);
    out_if.RDY = 1;
    in_if.ENA = 1;
    in_if.v = 32'h66;
    in_if.last = 1;
    tick();
    out_if.RDY = 0;
    in_if.ENA = 0;
    @(negedge CLK);
    chk("t4_pkt_count", 64'(pkt_count), 1);
    tick();
    out_if.RDY = 1;
    drain();
    @(negedge CLK);
    chk("t4_pkts_sent", 64'(pkts_sent), 8);
    tick();
    out_if.RDY = 0;
    beat(32'h1, 0);
    beat(32'h2, 0);
    nRST = 0;
    tick();
    nRST = 1;
    @(negedge CLK);
    chk("t5_pkt_count", 64'(pkt_count), 0);
    chk("t5_out_ena", 64'(out_if.ENA), 0);
    chk("t5_in_rdy", 64'(in_if.RDY), 1);
    tick();
    out_if.RDY = 1;
    beat(32'hAB, 1);
    drain();
    @(negedge CLK);
    chk("t5_pkts_sent", 64'(pkts_sent), 1);
    tick();
    done = 0;
    fork
      begin
        sent = 0;
        while (sent < 10000) begin
          len = $urandom_range(8, 1);
          for (int k = 0; k < len; k++) begin
            if ($urandom_range(3, 0) == 0) tick();
            beat($urandom, k == len - 1);
            sent++;
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          out_if.RDY = $urandom_range(3, 0) != 0;
          tick();
        end
      end
    join
    out_if.RDY = 1;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
